// File: rtl/core_run_ctrl.sv
// Program-load and run sequencer: assembles instruction words from a byte stream,
// holds the core in reset while loading, and gates its clock enable for run/halt/step.
module core_run_ctrl #(
  parameter int unsigned IMEM_AW = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic [7:0]         byte_in,
  input  logic               byte_vld,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_in,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  output logic               core_ce,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [7:0]         status
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PART_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic [PART_W-1:0]  word_q, word_d;
  logic               we_q, we_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [IMEM_AW-1:0] wa_q, wa_d;
  logic               ce_q, ce_d;
  logic               crst_q, crst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_prev_q, step_prev_q;
  logic               run_rise, step_rise;

  assign run_rise  = run_req & ~run_prev_q;
  assign step_rise = step_req & ~step_prev_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; load_req outranks halt_in, which outranks run/step requests
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_req)                 state_d = ST_LOAD;
        else if (run_req && !halt_in) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (!load_req) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (load_req)                 state_d = ST_IDLE;
        else if (halt_in || !run_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (load_req)                  state_d = ST_IDLE;
        else if (!halt_in && run_rise) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and load datapath; core controls are registered from the next state
  always_comb begin
    byte_idx_d = byte_idx_q;
    waddr_d    = waddr_q;
    word_d     = word_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    wa_d       = wa_q;
    cnt_d      = cnt_q;
    crst_d     = (state_d == ST_RUN) || (state_d == ST_HALT);
    ce_d       = (state_d == ST_RUN);

    if (ce_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          waddr_d    = '0;
          byte_idx_d = 2'd0;
          cnt_d      = '0;
        end
      end
      ST_LOAD: begin
        // A completing 4th byte is written even as load_req falls
        if (byte_vld && (byte_idx_q == 2'd3)) begin
          we_d       = 1'b1;
          wdata_d    = {byte_in, word_q};
          wa_d       = waddr_q;
          waddr_d    = waddr_q + IMEM_AW'(1);
          byte_idx_d = 2'd0;
        end else if (byte_vld && load_req) begin
          unique case (byte_idx_q)
            2'd0:    word_d[7:0]   = byte_in;
            2'd1:    word_d[15:8]  = byte_in;
            default: word_d[23:16] = byte_in;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
        end
        if (!load_req) byte_idx_d = 2'd0;
      end
      ST_HALT: begin
        if (!load_req && !halt_in && step_rise) ce_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= 2'd0;
      waddr_q     <= '0;
      word_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wa_q        <= '0;
      ce_q        <= 1'b0;
      crst_q      <= 1'b0;
      cnt_q       <= '0;
      run_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      waddr_q     <= waddr_d;
      word_q      <= word_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wa_q        <= wa_d;
      ce_q        <= ce_d;
      crst_q      <= crst_d;
      cnt_q       <= cnt_d;
      run_prev_q  <= run_req;
      step_prev_q <= step_req;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = wa_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = crst_q;
  assign core_ce    = ce_q;
  assign cyc_cnt    = cnt_q;
  assign status     = {state_q, byte_idx_q, waddr_q[3:0]};

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized and directed bench for core_run_ctrl against a queue-based behavioural model.
module tb_core_run_ctrl;

  localparam int unsigned IMEM_AW = 5;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CMAX    = 31;
  localparam int unsigned DEPTH   = 32;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_req = 1'b0;
  logic [7:0]         byte_in = 8'h00;
  logic               byte_vld = 1'b0;
  logic               run_req = 1'b0;
  logic               step_req = 1'b0;
  logic               halt_in = 1'b0;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic               core_rst_n;
  logic               core_ce;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [7:0]         status;

  core_run_ctrl #(.IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .byte_in    (byte_in),
    .byte_vld   (byte_vld),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_in    (halt_in),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .core_ce    (core_ce),
    .cyc_cnt    (cyc_cnt),
    .status     (status)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int wr_cnt = 0;

  // Behavioural model state
  int          m_mode;
  logic [7:0]  m_bytes[$];
  int          m_waddr;
  int          m_cnt;
  bit          m_ce, m_rst, m_we;
  logic [31:0] m_wdata;
  int          m_wa;
  bit          m_run_prev, m_step_prev;
  logic [31:0] gold_mem[DEPTH];
  logic [31:0] dut_mem[DEPTH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_bytes.delete(); m_waddr = 0; m_cnt = 0;
    m_ce = 0; m_rst = 0; m_we = 0; m_wdata = '0; m_wa = 0;
    m_run_prev = 0; m_step_prev = 0;
  endtask

  // One clock edge of the specified behaviour, from pre-edge inputs
  task automatic model_step();
    int          old_mode;
    bit          run_edge, step_edge;
    logic [31:0] word;
    old_mode  = m_mode;
    run_edge  = run_req && !m_run_prev;
    step_edge = step_req && !m_step_prev;
    if (m_ce && m_cnt < int'(CMAX)) m_cnt++;
    m_we = 0;
    case (old_mode)
      M_IDLE: begin
        if (load_req) begin
          m_mode = M_LOAD; m_waddr = 0; m_bytes.delete(); m_cnt = 0;
        end else if (run_req && !halt_in) m_mode = M_RUN;
      end
      M_LOAD: begin
        if (byte_vld && (load_req || m_bytes.size() == 3)) m_bytes.push_back(byte_in);
        if (m_bytes.size() == 4) begin
          word = 0;
          for (int k = 0; k < 4; k++) word = word | (32'(m_bytes[k]) << (8 * k));
          m_we = 1; m_wdata = word; m_wa = m_waddr;
          gold_mem[m_waddr] = word;
          m_waddr = (m_waddr + 1) % int'(DEPTH);
          m_bytes.delete();
        end
        if (!load_req) begin
          m_bytes.delete(); m_mode = M_IDLE;
        end
      end
      M_RUN: begin
        if (load_req) m_mode = M_IDLE;
        else if (halt_in || !run_req) m_mode = M_HALT;
      end
      default: begin
        if (load_req) m_mode = M_IDLE;
        else if (!halt_in && run_edge) m_mode = M_RUN;
      end
    endcase
    m_ce  = (m_mode == M_RUN) || (old_mode == M_HALT && m_mode == M_HALT && step_edge && !halt_in);
    m_rst = (m_mode == M_RUN) || (m_mode == M_HALT);
    m_run_prev  = run_req;
    m_step_prev = step_req;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_status;
    exp_status = {2'(m_mode), 2'(m_bytes.size()), 4'(m_waddr)};
    check_val("imem_we", 32'(imem_we), 32'(m_we));
    check_val("imem_waddr", 32'(imem_waddr), 32'(m_wa));
    check_val("imem_wdata", imem_wdata, m_wdata);
    check_val("core_rst_n", 32'(core_rst_n), 32'(m_rst));
    check_val("core_ce", 32'(core_ce), 32'(m_ce));
    check_val("cyc_cnt", 32'(cyc_cnt), 32'(m_cnt));
    check_val("status", 32'(status), 32'(exp_status));
    if (imem_we === 1'b1) begin
      dut_mem[imem_waddr] = imem_wdata;
      wr_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b; byte_vld = 1'b1;
    tick();
    byte_vld = 1'b0;
  endtask

  logic [31:0] words[33];
  int          ce_seen;
  int          bad_cells;
  bit          done;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin gold_mem[i] = '0; dut_mem[i] = '0; end
    model_reset();
    #3;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: two little-endian words
    load_req = 1'b1;
    tick();
    wr_cnt = 0;
    send_byte(8'h13); send_byte(8'h00); tick(); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hB7); send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
    tick();
    check_val("t1_writes", 32'(wr_cnt), 32'd2);
    check_val("t1_word0", dut_mem[0], 32'h0000_0013);
    check_val("t1_word1", dut_mem[1], 32'h0000_12B7);
    check_val("t1_waddr", 32'(status[3:0]), 32'd2);
    load_req = 1'b0;
    tick();

    // T2: partial word discarded
    wr_cnt = 0;
    load_req = 1'b1;
    tick();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    load_req = 1'b0;
    tick(); tick();
    check_val("t2_writes", 32'(wr_cnt), 32'd0);
    check_val("t2_state", 32'(status[7:6]), 32'd0);
    check_val("t2_byte_idx", 32'(status[5:4]), 32'd0);

    // T3: 33 words wrap to address 0
    load_req = 1'b1;
    tick();
    for (int w = 0; w < 33; w++) begin
      words[w] = $urandom;
      for (int k = 0; k < 4; k++) send_byte(8'(words[w] >> (8 * k)));
    end
    tick();
    check_val("t3_wrap_word", dut_mem[0], words[32]);
    bad_cells = 0;
    for (int i = 1; i < 32; i++) if (dut_mem[i] !== words[i]) bad_cells++;
    check_val("t3_other_cells", 32'(bad_cells), 32'd0);
    check_val("t3_waddr", 32'(status[3:0]), 32'd1);
    load_req = 1'b0;
    tick();

    // T4: run ten enabled cycles, then halt
    run_req = 1'b1;
    tick();
    check_val("t4_rst_release", 32'(core_rst_n), 32'd1);
    check_val("t4_ce_on", 32'(core_ce), 32'd1);
    ce_seen = 1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ce_seen == 10) done = 1;
      else begin
        tick();
        if (core_ce === 1'b1) ce_seen++;
      end
    end
    check_val("t4_run_budget", 32'(ce_seen), 32'd10);
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    check_val("t4_ce_off", 32'(core_ce), 32'd0);
    check_val("t4_cyc_cnt", 32'(cyc_cnt), 32'd10);

    // T5: held step_req gives one enabled cycle, twice
    for (int rep = 0; rep < 2; rep++) begin
      ce_seen = 0;
      step_req = 1'b1;
      repeat (5) begin tick(); if (core_ce === 1'b1) ce_seen++; end
      step_req = 1'b0;
      tick();
      if (core_ce === 1'b1) ce_seen++;
      check_val("t5_step_pulses", 32'(ce_seen), 32'd1);
      check_val("t5_cyc_cnt", 32'(cyc_cnt), 32'(11 + rep));
    end

    // T6: asynchronous reset while running
    run_req = 1'b0;
    tick();
    run_req = 1'b1;
    tick(); tick(); tick();
    check_val("t6_running", 32'(core_ce), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("t6_ce_async", 32'(core_ce), 32'd0);
    check_val("t6_rst_async", 32'(core_rst_n), 32'd0);
    check_val("t6_cnt_async", 32'(cyc_cnt), 32'd0);
    run_req = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check_val("t6_idle", 32'(status[7:6]), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) load_req = ~load_req;
      if ($urandom_range(0, 14) == 0) run_req = ~run_req;
      if ($urandom_range(0, 5) == 0)  step_req = ~step_req;
      halt_in  = ($urandom_range(0, 11) == 0);
      byte_vld = load_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      byte_in  = 8'($urandom);
      tick();
    end
    byte_vld = 1'b0;

    bad_cells = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (dut_mem[i] !== gold_mem[i]) bad_cells++;
    check_val("final_mem", 32'(bad_cells), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
